// File: rtl/cpu_pkg.sv
// ---------------------------------------------------------------------------
// cpu_pkg
// Shared definitions for the 16-bit-instruction / 8-bit-byte-memory CPU:
// default byte-address width, 4-bit opcode constants and the fetch-state enum.
// ---------------------------------------------------------------------------
package cpu_pkg;

  localparam int CPU_ADDR_W = 8;

  localparam logic [3:0] OP_HLT = 4'h0;
  localparam logic [3:0] OP_LDA = 4'h1;
  localparam logic [3:0] OP_ADD = 4'h2;
  localparam logic [3:0] OP_STO = 4'h3;
  localparam logic [3:0] OP_SUB = 4'h4;
  localparam logic [3:0] OP_JNZ = 4'h5;
  localparam logic [3:0] OP_JNC = 4'h6;
  localparam logic [3:0] OP_JMP = 4'h7;
  localparam logic [3:0] OP_NOP = 4'h8;
  localparam logic [3:0] OP_CM1 = 4'h9;

  typedef enum logic [1:0] {
    S_HI   = 2'd0,
    S_LO   = 2'd1,
    S_PUSH = 2'd2,
    S_HALT = 2'd3
  } fetch_state_t;

endpackage

// File: rtl/instr_queue.sv
// ---------------------------------------------------------------------------
// instr_queue
// QDEPTH-entry circular FIFO for fetched instructions (word + pc tag).
// Ports:
//   i_clock, i_reset_n  clock, async active-low reset
//   i_push, i_data      write one entry (ignored when full)
//   i_pop               remove head entry (ignored when empty)
//   i_flush             drop all entries, pointers back to 0 (wins over push/pop)
//   o_head              head entry, stable until popped
//   o_count             number of stored entries
//   o_full, o_empty     status flags
// ---------------------------------------------------------------------------
module instr_queue #(
  parameter int QDEPTH = 2,
  parameter int WIDTH  = 24
) (
  input  logic                       i_clock,
  input  logic                       i_reset_n,
  input  logic                       i_push,
  input  logic [WIDTH-1:0]           i_data,
  input  logic                       i_pop,
  input  logic                       i_flush,
  output logic [WIDTH-1:0]           o_head,
  output logic [$clog2(QDEPTH):0]    o_count,
  output logic                       o_full,
  output logic                       o_empty
);

  localparam int PTR_W = $clog2(QDEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] r_mem [QDEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;

  logic w_push_ok;
  logic w_pop_ok;

  assign o_full    = (r_count == CNT_W'(QDEPTH));
  assign o_empty   = (r_count == '0);
  assign o_count   = r_count;
  assign o_head    = r_mem[r_rd_ptr];
  assign w_push_ok = i_push & ~o_full;
  assign w_pop_ok  = i_pop & ~o_empty;

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      for (int i = 0; i < QDEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push_ok) begin
        r_mem[r_wr_ptr] <= i_data;
        r_wr_ptr        <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop_ok) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      case ({w_push_ok, w_pop_ok})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/instr_fetch.sv
// ---------------------------------------------------------------------------
// instr_fetch
// Fetch stage: reads two bytes per instruction (high byte first) from a
// synchronous byte memory, queues {word, pc} and hands the head to decode
// with valid/ready. Redirect flushes and restarts; an HLT stops fetching.
// Ports:
//   clock, reset_n            clock, async active-low reset
//   mem_rd, mem_addr          registered byte read strobe / address
//   mem_rdata                 read data, valid the cycle after mem_rd
//   ir_valid/ir_ready         head handshake; ir_data/ir_pc head word and pc
//   redirect_valid/_pc        flush and restart at redirect_pc (bit 0 forced 0)
//   halted                    fetch stopped after an HLT
//
// state  | meaning
// S_HI   | issue high-byte read when queue (incl. in-flight word) has room
// S_LO   | issue low-byte read at pc+1
// S_PUSH | high byte arriving; advance pc, HLT check
// S_HALT | no reads until redirect
// ---------------------------------------------------------------------------
module instr_fetch
  import cpu_pkg::*;
#(
  parameter int         ADDR_W = CPU_ADDR_W,
  parameter int         QDEPTH = 2,
  parameter logic [3:0] HLT_OP = OP_HLT
) (
  input  logic              clock,
  input  logic              reset_n,
  output logic              mem_rd,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [7:0]        mem_rdata,
  output logic              ir_valid,
  input  logic              ir_ready,
  output logic [15:0]       ir_data,
  output logic [ADDR_W-1:0] ir_pc,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              halted
);

  localparam int CNT_W = $clog2(QDEPTH) + 1;
  localparam int QW    = 16 + ADDR_W;

  fetch_state_t      r_state, w_state_nxt;
  logic [ADDR_W-1:0] r_pc, w_pc_nxt;
  logic              r_mem_rd, w_mem_rd_nxt;
  logic [ADDR_W-1:0] r_mem_addr, w_mem_addr_nxt;
  logic              r_rd_hi, w_rd_hi_nxt;
  logic [ADDR_W-1:0] r_rd_pc, w_rd_pc_nxt;
  logic              r_halted, w_halted_nxt;

  // Read-response tracking: memory answers one cycle after the strobe, so
  // the data path runs one cycle behind the FSM.
  logic              r_rsp_vld;
  logic              r_rsp_hi;
  logic [ADDR_W-1:0] r_rsp_pc;
  logic [7:0]        r_hi_byte;

  logic              w_pending;
  logic              w_push;
  logic              w_pop;
  logic [CNT_W-1:0]  w_q_count;
  logic [CNT_W:0]    w_fill;
  logic              w_space;
  logic              w_q_empty;
  logic              w_unused_q_full;
  logic              w_unused_pc0;
  logic [QW-1:0]     w_q_head;

  assign w_unused_pc0 = redirect_pc[0];

  // A low-byte response this cycle becomes a push at the edge, so it already
  // occupies a slot when S_HI decides whether to start the next fetch.
  assign w_pending = r_rsp_vld & ~r_rsp_hi;
  assign w_fill    = {1'b0, w_q_count} + (CNT_W+1)'(w_pending);
  assign w_space   = (w_fill < (CNT_W+1)'(QDEPTH));
  assign w_push    = w_pending & ~redirect_valid;
  assign w_pop     = ir_valid & ir_ready;

  instr_queue #(
    .QDEPTH (QDEPTH),
    .WIDTH  (QW)
  ) u_queue (
    .i_clock   (clock),
    .i_reset_n (reset_n),
    .i_push    (w_push),
    .i_data    ({r_hi_byte, mem_rdata, r_rsp_pc}),
    .i_pop     (w_pop),
    .i_flush   (redirect_valid),
    .o_head    (w_q_head),
    .o_count   (w_q_count),
    .o_full    (w_unused_q_full),
    .o_empty   (w_q_empty)
  );

  assign ir_valid = ~w_q_empty;
  assign ir_data  = w_q_head[QW-1:ADDR_W];
  assign ir_pc    = w_q_head[ADDR_W-1:0];
  assign mem_rd   = r_mem_rd;
  assign mem_addr = r_mem_addr;
  assign halted   = r_halted;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= S_HI;
      r_pc       <= '0;
      r_mem_rd   <= 1'b0;
      r_mem_addr <= '0;
      r_rd_hi    <= 1'b0;
      r_rd_pc    <= '0;
      r_halted   <= 1'b0;
      r_rsp_vld  <= 1'b0;
      r_rsp_hi   <= 1'b0;
      r_rsp_pc   <= '0;
      r_hi_byte  <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_pc       <= w_pc_nxt;
      r_mem_rd   <= w_mem_rd_nxt;
      r_mem_addr <= w_mem_addr_nxt;
      r_rd_hi    <= w_rd_hi_nxt;
      r_rd_pc    <= w_rd_pc_nxt;
      r_halted   <= w_halted_nxt;
      // Redirect kills the response to any strobe still on the bus.
      r_rsp_vld  <= r_mem_rd & ~redirect_valid;
      r_rsp_hi   <= r_rd_hi;
      r_rsp_pc   <= r_rd_pc;
      if (r_rsp_vld && r_rsp_hi) begin
        r_hi_byte <= mem_rdata;
      end
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_pc_nxt       = r_pc;
    w_mem_rd_nxt   = 1'b0;
    w_mem_addr_nxt = r_mem_addr;
    w_rd_hi_nxt    = r_rd_hi;
    w_rd_pc_nxt    = r_rd_pc;
    w_halted_nxt   = r_halted;

    if (redirect_valid) begin
      w_state_nxt  = S_HI;
      w_pc_nxt     = {redirect_pc[ADDR_W-1:1], 1'b0};
      w_halted_nxt = 1'b0;
    end else begin
      case (r_state)
        S_HI: begin
          if (w_space) begin
            w_mem_rd_nxt   = 1'b1;
            w_mem_addr_nxt = r_pc;
            w_rd_hi_nxt    = 1'b1;
            w_rd_pc_nxt    = r_pc;
            w_state_nxt    = S_LO;
          end
        end
        S_LO: begin
          w_mem_rd_nxt   = 1'b1;
          w_mem_addr_nxt = r_pc + ADDR_W'(1);
          w_rd_hi_nxt    = 1'b0;
          w_state_nxt    = S_PUSH;
        end
        S_PUSH: begin
          // mem_rdata carries the high byte in this state.
          w_pc_nxt = r_pc + ADDR_W'(2);
          if (mem_rdata[7:4] == HLT_OP) begin
            w_state_nxt  = S_HALT;
            w_halted_nxt = 1'b1;
          end else begin
            w_state_nxt = S_HI;
          end
        end
        S_HALT: begin
          w_halted_nxt = 1'b1;
        end
        default: begin
          w_state_nxt = S_HI;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
// ---------------------------------------------------------------------------
// tb_instr_fetch
// Directed bench for instr_fetch with a synchronous byte-memory model.
// Expected deliveries are queued by the stimulus; a monitor pops and compares
// on every accepted ir_valid/ir_ready beat. Read addresses are logged and
// compared against hand-derived sequences.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_instr_fetch;

  localparam int AW = 8;

  logic          clock = 1'b0;
  logic          reset_n = 1'b0;
  logic          mem_rd;
  logic [AW-1:0] mem_addr;
  logic [7:0]    mem_rdata = 8'h00;
  logic          ir_valid;
  logic          ir_ready = 1'b0;
  logic [15:0]   ir_data;
  logic [AW-1:0] ir_pc;
  logic          redirect_valid = 1'b0;
  logic [AW-1:0] redirect_pc = '0;
  logic          halted;

  logic [7:0]  mem [256];
  logic [23:0] exp_q [$];
  int          rd_log [$];
  int          n_cmp = 0;
  int          n_err = 0;

  instr_fetch #(
    .ADDR_W (AW),
    .QDEPTH (2),
    .HLT_OP (4'h0)
  ) dut (
    .clock          (clock),
    .reset_n        (reset_n),
    .mem_rd         (mem_rd),
    .mem_addr       (mem_addr),
    .mem_rdata      (mem_rdata),
    .ir_valid       (ir_valid),
    .ir_ready       (ir_ready),
    .ir_data        (ir_data),
    .ir_pc          (ir_pc),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .halted         (halted)
  );

  always #5 clock = ~clock;

  always @(posedge clock) begin
    if (mem_rd) mem_rdata <= mem[mem_addr];
  end

  always @(negedge clock) begin
    if (mem_rd) rd_log.push_back(int'(mem_addr));
  end

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  // Scoreboard monitor
  always @(negedge clock) begin
    logic [23:0] e;
    if (ir_valid && ir_ready) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_pop: got data=0x%04h pc=%0d, required no delivery", ir_data, ir_pc);
      end else begin
        e = exp_q.pop_front();
        chk("pop_data", int'(ir_data), int'(e[23:8]));
        chk("pop_pc", int'(ir_pc), int'(e[7:0]));
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic exp_add(input logic [15:0] d, input logic [7:0] pc);
    exp_q.push_back({d, pc});
  endtask

  task automatic load_default();
    for (int i = 0; i < 256; i++) mem[i] = 8'(8'h80 + (i % 16));
  endtask

  task automatic load_prog1();
    load_default();
    mem[0] = 8'h70; mem[1] = 8'h14;
    mem[2] = 8'h20; mem[3] = 8'h05;
    mem[4] = 8'h00; mem[5] = 8'h00;
  endtask

  task automatic check_reset_vals(input string pfx);
    chk({pfx, "_rst_mem_rd"},   int'(mem_rd),   0);
    chk({pfx, "_rst_mem_addr"}, int'(mem_addr), 0);
    chk({pfx, "_rst_ir_valid"}, int'(ir_valid), 0);
    chk({pfx, "_rst_ir_data"},  int'(ir_data),  0);
    chk({pfx, "_rst_ir_pc"},    int'(ir_pc),    0);
    chk({pfx, "_rst_halted"},   int'(halted),   0);
  endtask

  task automatic do_reset(input string pfx, input logic rdy);
    reset_n        = 1'b0;
    ir_ready       = rdy;
    redirect_valid = 1'b0;
    tick(2);
    check_reset_vals(pfx);
    exp_q.delete();
    rd_log.delete();
    reset_n = 1'b1;
  endtask

  // Wait until every expected word is delivered and fetch is halted and empty.
  task automatic wait_idle(input string pfx, input int max_cyc);
    int n = 0;
    while (!(halted && !ir_valid && exp_q.size() == 0) && n < max_cyc) begin
      tick(1);
      n++;
    end
    chk({pfx, "_idle_reached"}, int'(halted && !ir_valid && exp_q.size() == 0), 1);
    tick(3);
    chk({pfx, "_drained"}, exp_q.size(), 0);
  endtask

  task automatic chk_log(input string pfx, input int idx, input int exp);
    if (idx < rd_log.size()) chk({pfx, "_rd_addr"}, rd_log[idx], exp);
    else chk({pfx, "_rd_missing"}, rd_log.size(), idx + 1);
  endtask

  task automatic pulse_redirect(input logic [7:0] pc);
    redirect_pc    = pc;
    redirect_valid = 1'b1;
    tick(1);
    redirect_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1);
  end

  initial begin
    // T1: basic fetch, latency, HLT, halt hold, redirect resumes
    load_prog1();
    do_reset("t1", 1'b1);
    exp_add(16'h7014, 8'd0); exp_add(16'h2005, 8'd2); exp_add(16'h0000, 8'd4);
    tick(3);
    chk("t1_valid_cyc3", int'(ir_valid), 0);
    tick(1);
    chk("t1_valid_cyc4", int'(ir_valid), 1);
    wait_idle("t1", 200);
    chk("t1_rd_count", rd_log.size(), 6);
    for (int i = 0; i < 6; i++) chk_log("t1", i, i);
    tick(20);
    chk("t1_halt_no_reads", rd_log.size(), 6);
    chk("t1_halted", int'(halted), 1);
    exp_add(16'h7014, 8'd0); exp_add(16'h2005, 8'd2); exp_add(16'h0000, 8'd4);
    pulse_redirect(8'd0);
    chk("t1_halt_cleared", int'(halted), 0);
    chk("t1_redir_valid0", int'(ir_valid), 0);
    wait_idle("t1b", 200);
    chk("t1b_rd_count", rd_log.size(), 12);
    for (int i = 0; i < 6; i++) chk_log("t1b", 6 + i, i);

    // T2: consumer stalled from reset
    load_prog1();
    do_reset("t2", 1'b0);
    exp_add(16'h7014, 8'd0); exp_add(16'h2005, 8'd2); exp_add(16'h0000, 8'd4);
    tick(20);
    chk("t2_rd_count_full", rd_log.size(), 4);
    for (int i = 0; i < 4; i++) chk_log("t2", i, i);
    chk("t2_valid", int'(ir_valid), 1);
    chk("t2_data", int'(ir_data), 'h7014);
    chk("t2_pc", int'(ir_pc), 0);
    tick(5);
    chk("t2_data_stable", int'(ir_data), 'h7014);
    chk("t2_no_more_reads", rd_log.size(), 4);
    ir_ready = 1'b1;
    wait_idle("t2", 200);
    chk("t2_rd_count_end", rd_log.size(), 6);

    // T3: redirect to 21 while the first fetch is in S_LO
    load_default();
    mem[20] = 8'h35; mem[21] = 8'hAA; mem[22] = 8'h00; mem[23] = 8'h00;
    do_reset("t3", 1'b1);
    exp_add(16'h35AA, 8'd20); exp_add(16'h0000, 8'd22);
    tick(1);
    pulse_redirect(8'd21);
    chk("t3_redir_valid0", int'(ir_valid), 0);
    wait_idle("t3", 200);
    chk("t3_rd_count", rd_log.size(), 5);
    chk_log("t3", 0, 0);
    for (int i = 0; i < 4; i++) chk_log("t3", 1 + i, 20 + i);

    // T4: redirect flushes a full queue
    do_reset("t4", 1'b0);
    tick(12);
    chk("t4_full_valid", int'(ir_valid), 1);
    pulse_redirect(8'd20);
    chk("t4_flush_valid0", int'(ir_valid), 0);
    exp_add(16'h35AA, 8'd20); exp_add(16'h0000, 8'd22);
    ir_ready = 1'b1;
    wait_idle("t4", 200);
    chk("t4_rd_count", rd_log.size(), 8);
    for (int i = 0; i < 4; i++) chk_log("t4", i, i);
    for (int i = 0; i < 4; i++) chk_log("t4", 4 + i, 20 + i);

    // T5: address wrap at 254/255
    load_default();
    mem[0] = 8'h00; mem[1] = 8'h00; mem[254] = 8'h10; mem[255] = 8'h04;
    do_reset("t5", 1'b1);
    exp_add(16'h0000, 8'd0);
    wait_idle("t5", 200);
    chk("t5_rd_count0", rd_log.size(), 2);
    exp_add(16'h1004, 8'd254); exp_add(16'h0000, 8'd0);
    pulse_redirect(8'd254);
    chk("t5_halt_cleared", int'(halted), 0);
    wait_idle("t5b", 200);
    chk("t5_rd_count", rd_log.size(), 6);
    chk_log("t5", 2, 254);
    chk_log("t5", 3, 255);
    chk_log("t5", 4, 0);
    chk_log("t5", 5, 1);

    // T6: async reset pulse during S_PUSH with one entry queued
    load_prog1();
    do_reset("t6a", 1'b0);
    tick(5);
    chk("t6_pre_valid", int'(ir_valid), 1);
    chk("t6_pre_mem_rd", int'(mem_rd), 1);
    reset_n = 1'b0;
    #1;
    check_reset_vals("t6");
    @(posedge clock);
    #1;
    rd_log.delete();
    exp_q.delete();
    exp_add(16'h7014, 8'd0); exp_add(16'h2005, 8'd2); exp_add(16'h0000, 8'd4);
    ir_ready = 1'b1;
    reset_n  = 1'b1;
    wait_idle("t6", 200);
    chk("t6_rd_count", rd_log.size(), 6);
    chk_log("t6", 0, 0);
    chk_log("t6", 1, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
